// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  localparam int ICACHE_LINE_WORDS     = 4;
  localparam int ICACHE_OFFSET_BITS    = 2;
  localparam int ICACHE_LINE_BYTE_BITS = 4;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one word write port.
// Latency: read is combinational; writes land on the rising edge.
// Backpressure: none; the caller gates every write enable.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 32 - ICACHE_LINE_BYTE_BITS - INDEX_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INDEX_BITS-1:0]         i_rd_idx,
  input  logic [ICACHE_OFFSET_BITS-1:0] i_rd_off,
  output logic                          o_rd_vld,
  output logic [TAG_BITS-1:0]           o_rd_tag,
  output logic [31:0]                   o_rd_dat,
  input  logic                          i_wr_en,
  input  logic [INDEX_BITS-1:0]         i_wr_idx,
  input  logic [ICACHE_OFFSET_BITS-1:0] i_wr_off,
  input  logic [31:0]                   i_wr_dat,
  input  logic                          i_fill_en,
  input  logic [TAG_BITS-1:0]           i_fill_tag,
  input  logic                          i_clr_en,
  input  logic [INDEX_BITS-1:0]         i_clr_idx
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES][ICACHE_LINE_WORDS];

  assign o_rd_vld = r_valid[i_rd_idx];
  assign o_rd_tag = r_tag[i_rd_idx];
  assign o_rd_dat = r_data[i_rd_idx][i_rd_off];

  // Valid bits: only state here that reset touches; cleared at refill start, set on fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clr_en)  r_valid[i_clr_idx] <= 1'b0;
      if (i_fill_en) r_valid[i_wr_idx]  <= 1'b1;
    end
  end

  // Tag and data arrays are plain storage; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (i_wr_en)   r_data[i_wr_idx][i_wr_off] <= i_wr_dat;
    if (i_fill_en) r_tag[i_wr_idx]            <= i_fill_tag;
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped I-cache: combinational PC lookup, 4-word line refill on miss.
// Latency: hit in 0 cycles; miss costs 1 request cycle plus one cycle per word.
// Backpressure: rdy low freezes everything; refill words accepted only on mem_valid.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] pc,
  output logic        hit,
  output logic [31:0] inst_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int TAG_LSB  = ICACHE_LINE_BYTE_BITS + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LSB;
  localparam logic [ICACHE_OFFSET_BITS-1:0] LAST_WORD = ICACHE_OFFSET_BITS'(LINE_WORDS - 1);

  icache_state_t                 r_state;
  icache_state_t                 w_state_nxt;
  logic [ICACHE_OFFSET_BITS-1:0] r_cnt;
  logic                          r_mem_req;
  logic [31:0]                   r_mem_addr;

  logic [INDEX_BITS-1:0]         w_pc_idx;
  logic [TAG_BITS-1:0]           w_pc_tag;
  logic [ICACHE_OFFSET_BITS-1:0] w_pc_off;
  logic                          w_rd_vld;
  logic [TAG_BITS-1:0]           w_rd_tag;
  logic [31:0]                   w_rd_dat;
  logic                          w_miss_start;
  logic                          w_word_wr;
  logic                          w_line_done;
  logic                          w_unused_pc_lo;

  assign w_pc_off       = pc[ICACHE_LINE_BYTE_BITS-1:2];
  assign w_pc_idx       = pc[TAG_LSB-1:ICACHE_LINE_BYTE_BITS];
  assign w_pc_tag       = pc[31:TAG_LSB];
  assign w_unused_pc_lo = ^pc[1:0];

  // A hit is only reported while idle so a half-written line is never served.
  assign hit      = (r_state == IDLE) && w_rd_vld && (w_rd_tag == w_pc_tag);
  assign inst_out = hit ? w_rd_dat : 32'h0;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  // The latched refill address doubles as the refill index/tag source.
  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_line_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_pc_idx),
    .i_rd_off   (w_pc_off),
    .o_rd_vld   (w_rd_vld),
    .o_rd_tag   (w_rd_tag),
    .o_rd_dat   (w_rd_dat),
    .i_wr_en    (w_word_wr),
    .i_wr_idx   (r_mem_addr[TAG_LSB-1:ICACHE_LINE_BYTE_BITS]),
    .i_wr_off   (r_cnt),
    .i_wr_dat   (mem_data),
    .i_fill_en  (w_line_done),
    .i_fill_tag (r_mem_addr[31:TAG_LSB]),
    .i_clr_en   (w_miss_start),
    .i_clr_idx  (w_pc_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle strobes; rdy low suppresses every strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_miss_start = 1'b0;
    w_word_wr    = 1'b0;
    w_line_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rdy && !hit) begin
          w_miss_start = 1'b1;
          w_state_nxt  = REFILL;
        end
      end
      REFILL: begin
        if (rdy && mem_valid) begin
          w_word_wr = 1'b1;
          if (r_cnt == LAST_WORD) begin
            w_line_done = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Refill counter and memory request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
    end else if (w_miss_start) begin
      r_cnt      <= '0;
      r_mem_req  <= 1'b1;
      r_mem_addr <= {pc[31:ICACHE_LINE_BYTE_BITS], {ICACHE_LINE_BYTE_BITS{1'b0}}};
    end else if (w_word_wr) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_line_done) r_mem_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: reference line model plus expectation queue.
// Latency: lookups checked 1ns after pc changes; registered outputs 1ns after posedge.
// Backpressure: exercises word gaps and rdy stalls during refill.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] pc;
  logic        hit;
  logic [31:0] inst_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  always #5 clk = ~clk;

  icache #(.INDEX_BITS(4), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .pc        (pc),
    .hit       (hit),
    .inst_out  (inst_out),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  // Reference model of resident lines.
  logic        ref_vld [16];
  logic [23:0] ref_tag [16];
  logic [31:0] ref_dat [16][4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    e = sb_q.pop_front();
    check_val(e.tag, got, e.val);
  endtask

  function automatic logic exp_hit(input logic [31:0] a);
    return ref_vld[a[7:4]] && (ref_tag[a[7:4]] == a[31:8]);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return exp_hit(a) ? ref_dat[a[7:4]][a[3:2]] : 32'h0;
  endfunction

  // Combinational lookup while idle; called in the low phase of the clock.
  task automatic lookup(input logic [31:0] a);
    pc = a;
    #1;
    sb_push($sformatf("hit@%0h", a), 32'(exp_hit(a)));
    sb_push($sformatf("inst@%0h", a), exp_inst(a));
    sb_pop(32'(hit));
    sb_pop(inst_out);
  endtask

  // Drive one full refill; pc must already miss on line a. Returns in the low phase.
  task automatic refill(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] step,
                        input int gap, input int stall_after, input int sw_after,
                        input logic [31:0] sw_pc);
    logic [31:0] line;
    logic [3:0]  idx;
    logic [31:0] wd;
    line = {a[31:4], 4'h0};
    idx  = a[7:4];
    @(posedge clk); #1;
    ref_vld[idx] = 1'b0;
    sb_push("req_rise", 32'h1);
    sb_push("req_addr", line);
    sb_pop(32'(mem_req));
    sb_pop(mem_addr);
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); mem_valid = 1'b0;
        @(posedge clk); #1;
        sb_push("gap_req", 32'h1);
        sb_push("gap_addr", line);
        sb_pop(32'(mem_req));
        sb_pop(mem_addr);
      end
      if (w == stall_after) begin
        for (int s = 0; s < 2; s++) begin
          @(negedge clk); rdy = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
          @(posedge clk); #1;
          sb_push("stall_req", 32'h1);
          sb_push("stall_addr", line);
          sb_pop(32'(mem_req));
          sb_pop(mem_addr);
        end
      end
      wd = d0 + 32'(w) * step;
      @(negedge clk);
      rdy = 1'b1;
      if (w == sw_after) pc = sw_pc;
      mem_valid = 1'b1;
      mem_data  = wd;
      #1;
      sb_push("refill_hit", 32'h0);
      sb_pop(32'(hit));
      @(posedge clk); #1;
      ref_dat[idx][w[1:0]] = wd;
      sb_push((w < 3) ? "word_req" : "done_req", (w < 3) ? 32'h1 : 32'h0);
      sb_push("word_addr", line);
      sb_pop(32'(mem_req));
      sb_pop(mem_addr);
    end
    ref_vld[idx] = 1'b1;
    ref_tag[idx] = a[31:8];
    sb_push("done_hit", 32'(exp_hit(pc)));
    sb_push("done_inst", exp_inst(pc));
    sb_pop(32'(hit));
    sb_pop(inst_out);
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    rdy       = 1'b0;
    pc        = 32'h0;
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;

    // Reset state.
    #1;
    sb_push("rst_req", 32'h0);
    sb_push("rst_addr", 32'h0);
    sb_push("rst_hit", 32'h0);
    sb_push("rst_inst", 32'h0);
    sb_pop(32'(mem_req));
    sb_pop(mem_addr);
    sb_pop(32'(hit));
    sb_pop(inst_out);
    @(negedge clk);
    rst_n = 1'b1;

    // No false hit before any refill (rdy low keeps the FSM idle).
    for (int i = 0; i < 64; i++) lookup(32'(i * 4));
    @(negedge clk);
    sb_push("sweep_req", 32'h0);
    sb_pop(32'(mem_req));
    rdy = 1'b1;

    // Cold miss with custom words.
    lookup(32'h0);
    refill(32'h0, 32'h11, 32'h11, 0, -1, -1, 32'h0);
    lookup(32'h0);
    lookup(32'h8);
    @(posedge clk); #1;
    sb_push("cold_noreq", 32'h0);
    sb_pop(32'(mem_req));
    @(negedge clk);

    // Conflict eviction at index 0.
    lookup(32'h100);
    refill(32'h100, 32'h100, 32'h4, 0, -1, -1, 32'h0);
    lookup(32'h104);
    lookup(32'h0);
    refill(32'h0, 32'h0, 32'h4, 0, -1, -1, 32'h0);
    lookup(32'h4);

    // PC change mid-refill.
    lookup(32'h40);
    refill(32'h40, 32'h40, 32'h4, 0, -1, 2, 32'h84);
    lookup(32'h84);
    refill(32'h84, 32'h80, 32'h4, 0, -1, -1, 32'h0);
    lookup(32'h44);

    // Gapped delivery, rdy stall, pc moved to a resident line during refill.
    lookup(32'h200);
    refill(32'h200, 32'h200, 32'h4, 3, 2, 0, 32'h48);
    lookup(32'h20C);

    // Async reset mid-refill: evict 0x40, restart its refill, abort after 2 words.
    lookup(32'h140);
    refill(32'h140, 32'h140, 32'h4, 0, -1, -1, 32'h0);
    lookup(32'h40);
    @(posedge clk); #1;
    ref_vld[4] = 1'b0;
    sb_push("abort_req", 32'h1);
    sb_push("abort_addr", 32'h40);
    sb_pop(32'(mem_req));
    sb_pop(mem_addr);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk); mem_valid = 1'b1; mem_data = 32'h40 + 32'(w) * 32'h4;
      @(posedge clk); #1;
    end
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
    sb_push("arst_req", 32'h0);
    sb_push("arst_addr", 32'h0);
    sb_push("arst_hit", 32'h0);
    sb_push("arst_inst", 32'h0);
    sb_pop(32'(mem_req));
    sb_pop(mem_addr);
    sb_pop(32'(hit));
    sb_pop(inst_out);
    #1;
    rst_n = 1'b1;
    lookup(32'h40);
    refill(32'h40, 32'h40, 32'h4, 0, -1, -1, 32'h0);
    lookup(32'h84);
    lookup(32'h48);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
